tank_sensor_scanner: RTL and testbench

Parametrised successor to the aquarium sensor register/mux path. It holds CHANNELS sensor registers of WIDTH bits, e.g. fish count, cleanliness, temperature, food, saltiness. It checks each write against per-channel limits and keeps a sticky alarm per channel. One registered output is driven in one of four modes: idle, manual one-hot select, automatic round-robin scan with a programmable dwell time, or error.

---
 rtl/tank_sensor_scanner.sv | 238 +++++++++++++++++++++++
 tb/tb_tank_sensor_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_sensor_scanner.sv
// Tank sensor scanner: a bank of CHANNELS sensor registers with per-channel
// limit checking and sticky alarms, plus one registered output port driven
// in IDLE, MANUAL (one-hot select), SCAN (round-robin with dwell) or ERROR.
module tank_sensor_scanner #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 5,
    parameter int DWELL    = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [CHANNELS*WIDTH-1:0] lim_lo,
    input  logic [CHANNELS*WIDTH-1:0] lim_hi,
    input  logic [CHANNELS-1:0]       alarm_clr,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       sel,
    output logic [WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]       out_sel,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       alarm,
    output logic                      err,
    output logic                      scan_wrap
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_SCAN   = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [WIDTH-1:0]      bank_reg [CHANNELS];
    logic [CHANNELS-1:0]   alarm_reg;
    logic [CHANNELS-1:0]   alarm_next;
    logic [CHANNELS-1:0]   alarm_set;
    logic [CHANNELS-1:0]   sel_reg;

    logic [PTR_W-1:0]      ptr_reg;
    logic [DW_W-1:0]       dwell_reg;
    logic                  scan_wrap_reg;
    logic                  scan_enter;
    logic                  scan_advance;

    logic                  sel_onehot;
    logic [CHANNELS-1:0]   scan_onehot;
    logic [CHANNELS-1:0]   view_sel;
    logic [WIDTH-1:0]      view_data;

    logic [WIDTH-1:0]      out_reg;
    logic [WIDTH-1:0]      out_next;
    logic [CHANNELS-1:0]   out_sel_reg;
    logic [CHANNELS-1:0]   out_sel_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic                  err_reg;
    logic                  err_next;

    // A select is usable only if exactly one bit is set.
    assign sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

    // Per-channel limit check: only a write can raise an alarm, and a raise
    // takes priority over a clear arriving on the same edge.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_alarm
            logic [WIDTH-1:0] lo_w;
            logic [WIDTH-1:0] hi_w;
            assign lo_w = lim_lo[gi*WIDTH +: WIDTH];
            assign hi_w = lim_hi[gi*WIDTH +: WIDTH];
            assign alarm_set[gi]  = wr_en[gi] && ((wr_data < lo_w) || (wr_data > hi_w));
            assign alarm_next[gi] = alarm_set[gi] | (alarm_reg[gi] & ~alarm_clr[gi]);
        end
    endgenerate

    // Sensor register bank: every enabled channel loads the shared write data.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i]) begin
                    bank_reg[i] <= wr_data;
                end
            end
        end
    end

    // Sticky alarm flags.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            alarm_reg <= '0;
        end else begin
            alarm_reg <= alarm_next;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; ERROR can only be left through IDLE.
    always_comb begin
        state_next = state_reg;
        case (mode)
            2'b00: state_next = ST_IDLE;
            2'b01: begin
                if (state_reg == ST_ERROR) begin
                    state_next = ST_ERROR;
                end else if (sel_onehot) begin
                    state_next = ST_MANUAL;
                end else begin
                    state_next = ST_ERROR;
                end
            end
            2'b10: begin
                if (state_reg == ST_ERROR) begin
                    state_next = ST_ERROR;
                end else begin
                    state_next = ST_SCAN;
                end
            end
            default: state_next = ST_ERROR;
        endcase
    end

    // Remember the manual select so the output stays on a validated channel.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sel_reg <= '0;
        end else if (state_next == ST_MANUAL) begin
            sel_reg <= sel;
        end
    end

    assign scan_enter   = (state_next == ST_SCAN) && (state_reg != ST_SCAN);
    assign scan_advance = (state_next == ST_SCAN) && (state_reg == ST_SCAN);

    // Scan pointer and dwell counter; restart at channel 0 on every entry,
    // hold while not scanning, and flag the wrap back to channel 0.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ptr_reg       <= '0;
            dwell_reg     <= '0;
            scan_wrap_reg <= 1'b0;
        end else begin
            scan_wrap_reg <= 1'b0;
            if (scan_enter) begin
                ptr_reg   <= '0;
                dwell_reg <= '0;
            end else if (scan_advance) begin
                if (dwell_reg == DWELL_LAST) begin
                    dwell_reg <= '0;
                    if (ptr_reg == PTR_LAST) begin
                        ptr_reg       <= '0;
                        scan_wrap_reg <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end else begin
                    dwell_reg <= dwell_reg + 1'b1;
                end
            end
        end
    end

    assign scan_onehot = CHANNELS'(1) << ptr_reg;
    assign view_sel    = (state_reg == ST_SCAN) ? scan_onehot : sel_reg;

    // One-hot read mux shared by MANUAL and SCAN.
    always_comb begin
        view_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (view_sel[i]) begin
                view_data = view_data | bank_reg[i];
            end
        end
    end

    // Output decode from the current state.
    always_comb begin
        out_next       = '0;
        out_sel_next   = '0;
        out_valid_next = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            ST_MANUAL, ST_SCAN: begin
                out_next       = view_data;
                out_sel_next   = view_sel;
                out_valid_next = 1'b1;
            end
            ST_ERROR: begin
                out_next = '1;
                err_next = 1'b1;
            end
            default: begin
                out_next = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_reg       <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            out_reg       <= out_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

    assign out       = out_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;
    assign alarm     = alarm_reg;
    assign err       = err_reg;
    assign scan_wrap = scan_wrap_reg;

endmodule

// File: tb/tb_tank_sensor_scanner.sv
// Self-checking bench for tank_sensor_scanner: a cycle model driven from the
// behavioural rules plus hand-computed expectations for the directed tests.
module tb_tank_sensor_scanner;

    localparam int W = 8;
    localparam int C = 5;
    localparam int D = 4;

    logic           CLK;
    logic           reset;
    logic [C-1:0]   wr_en;
    logic [W-1:0]   wr_data;
    logic [C*W-1:0] lim_lo;
    logic [C*W-1:0] lim_hi;
    logic [C-1:0]   alarm_clr;
    logic [1:0]     mode;
    logic [C-1:0]   sel;
    logic [W-1:0]   out;
    logic [C-1:0]   out_sel;
    logic           out_valid;
    logic [C-1:0]   alarm;
    logic           err;
    logic           scan_wrap;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    tank_sensor_scanner #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .lim_lo(lim_lo), .lim_hi(lim_hi), .alarm_clr(alarm_clr),
        .mode(mode), .sel(sel), .out(out), .out_sel(out_sel),
        .out_valid(out_valid), .alarm(alarm), .err(err), .scan_wrap(scan_wrap)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State 0 idle, 1 manual, 2 scan, 3 error; scan position derived from the
    // number of edges spent in scan since entry.
    int           m_state;
    int           m_age;
    logic [C-1:0] m_sel;
    logic [W-1:0] m_regs [C];
    logic [C-1:0] m_alarm;
    logic [W-1:0] exp_out;
    logic [C-1:0] exp_sel;
    logic         exp_valid;
    logic [C-1:0] exp_alarm;
    logic         exp_err;
    logic         exp_wrap;

    always @(posedge CLK or posedge reset) begin : model
        int ns;
        int p;
        if (reset) begin
            m_state = 0; m_age = 0; m_sel = '0; m_alarm = '0;
            for (int i = 0; i < C; i++) m_regs[i] = '0;
            exp_out = '0; exp_sel = '0; exp_valid = 0;
            exp_alarm = '0; exp_err = 0; exp_wrap = 0;
        end else begin
            exp_out = '0; exp_sel = '0; exp_valid = 0; exp_err = 0;
            case (m_state)
                1: begin
                    for (int i = 0; i < C; i++) if (m_sel[i]) exp_out = m_regs[i];
                    exp_sel = m_sel; exp_valid = 1;
                end
                2: begin
                    p = (m_age / D) % C;
                    exp_out = m_regs[p]; exp_sel = C'(1 << p); exp_valid = 1;
                end
                3: begin
                    exp_out = 8'hFF; exp_err = 1;
                end
                default: ;
            endcase
            case (mode)
                2'd0: ns = 0;
                2'd1: ns = (m_state == 3) ? 3 : (($countones(sel) == 1) ? 1 : 3);
                2'd2: ns = (m_state == 3) ? 3 : 2;
                default: ns = 3;
            endcase
            exp_wrap = (m_state == 2) && (ns == 2) && (((m_age + 1) % (D * C)) == 0);
            for (int i = 0; i < C; i++) begin
                if (wr_en[i] && ((wr_data < lim_lo[i*W +: W]) || (wr_data > lim_hi[i*W +: W])))
                    m_alarm[i] = 1;
                else if (alarm_clr[i])
                    m_alarm[i] = 0;
                if (wr_en[i]) m_regs[i] = wr_data;
            end
            exp_alarm = m_alarm;
            if (ns == 1) m_sel = sel;
            if (ns == 2) m_age = (m_state == 2) ? m_age + 1 : 0;
            m_state = ns;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_out", out, exp_out);
            chk("m_out_sel", out_sel, exp_sel);
            chk("m_out_valid", out_valid, exp_valid);
            chk("m_alarm", alarm, exp_alarm);
            chk("m_err", err, exp_err);
            chk("m_scan_wrap", scan_wrap, exp_wrap);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic write_ch(input int ch, input logic [W-1:0] d);
        wr_en = C'(1 << ch);
        wr_data = d;
        tick();
        wr_en = '0;
        $display("write ch%0d = %02h  alarm=%b", ch, d, alarm);
    endtask

    logic [W-1:0] vals [C];
    int wraps;

    initial begin
        vals = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70};
        reset = 1; wr_en = '0; wr_data = '0; lim_lo = '0; lim_hi = '1;
        alarm_clr = '0; mode = 2'b00; sel = '0;
        tick();
        cmp_en = 1;
        tick();
        reset = 0;
        tick();
        $display("reset released: out=%02h out_sel=%b alarm=%b", out, out_sel, alarm);
        chk("rst_out", out, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_err", err, 0);
        chk("rst_wrap", scan_wrap, 0);

        // Manual read of ch2
        write_ch(1, 8'h0E);
        write_ch(2, 8'h1C);
        mode = 2'b01; sel = 5'b00100;
        tick();
        chk("man_one_edge_out_sel", out_sel, 0);
        tick();
        $display("manual sel=%b: out=%02h out_sel=%b valid=%b", sel, out, out_sel, out_valid);
        chk("man_out", out, 8'h1C);
        chk("man_out_sel", out_sel, 5'b00100);
        chk("man_valid", out_valid, 1);

        // Alarm on ch3
        lim_lo[3*W +: W] = 8'h20;
        lim_hi[3*W +: W] = 8'h40;
        write_ch(3, 8'h50);
        chk("alm_set", alarm, 5'b01000);
        write_ch(3, 8'h30);
        chk("alm_inrange_keeps", alarm, 5'b01000);
        alarm_clr = 5'b01000;
        write_ch(3, 8'h50);
        chk("alm_set_wins", alarm, 5'b01000);
        tick();
        alarm_clr = '0;
        $display("alarm clear alone: alarm=%b", alarm);
        chk("alm_cleared", alarm, 5'b00000);

        // Scan through all channels
        for (int i = 0; i < C; i++) write_ch(i, vals[i]);
        chk("scan_setup_alarm", alarm, 0);
        mode = 2'b10;
        tick();
        wraps = 0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            $display("scan cycle %0d: out=%02h out_sel=%b wrap=%b", k, out, out_sel, scan_wrap);
            chk("scan_out", out, vals[((k - 1) / D) % C]);
            if (scan_wrap) wraps++;
            if (k == 20) chk("scan_wrap_at_end", scan_wrap, 1);
        end
        chk("scan_wrap_count", wraps, 1);

        // Error handling
        mode = 2'b01; sel = 5'b00110;
        tick(); tick();
        $display("error sel=%b: err=%b out=%02h valid=%b", sel, err, out, out_valid);
        chk("err_flag", err, 1);
        chk("err_out", out, 8'hFF);
        chk("err_valid", out_valid, 0);
        mode = 2'b10;
        tick(); tick();
        chk("err_sticky_scan", err, 1);
        mode = 2'b00;
        tick(); tick();
        chk("err_idle_err", err, 0);
        chk("err_idle_out", out, 0);
        mode = 2'b01; sel = 5'b00001;
        tick(); tick();
        $display("manual after error: out=%02h", out);
        chk("err_recover_out", out, 8'h07);

        // Reset in the middle of a scan (ch2, dwell 2)
        mode = 2'b10;
        tick();
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_out", out, 8'h1C);
        reset = 1;
        #1;
        $display("async reset mid-scan: out=%02h out_sel=%b valid=%b", out, out_sel, out_valid);
        chk("arst_out", out, 0);
        chk("arst_out_sel", out_sel, 0);
        chk("arst_valid", out_valid, 0);
        tick();
        reset = 0;
        tick(); tick();
        $display("scan after reset: out=%02h out_sel=%b", out, out_sel);
        chk("rescan_out", out, 8'h00);
        chk("rescan_out_sel", out_sel, 5'b00001);
        chk("rescan_valid", out_valid, 1);

        mode = 2'b00;
        tick(); tick();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
